floating_point_vec_driver: RTL and testbench
============================================

FLOATING_POINT_VEC_DRIVER -- requirements
Module: floating_point_vec_driver

Interface
REQ-001 SHALL have parameter NUM_VEC, default 20, the number of ROM vectors sent per run; legal range 1..32.
REQ-002 SHALL have parameter ADDR_W, default 5, the ROM address width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, a one-cycle run request, sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1, a synchronous run cancel.
REQ-007 SHALL have port rd_addr, output, ADDR_W, the ROM read address.
REQ-008 SHALL have port rom_dout, input, 32, the ROM read data, registered in the ROM with 1-cycle latency.
REQ-009 SHALL have port a_tdata, output, 32, the operand to the floating-point core.
REQ-010 SHALL have port a_tvalid, output, 1, operand valid.
REQ-011 SHALL have port a_tready, input, 1, operand ready from the core.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-013 SHALL have port done, output, 1, a one-cycle pulse when a run completes.
REQ-014 SHALL have port vec_cnt, output, 6, the count of handshakes accepted in the current or last run.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, LOAD, SEND, DONE.
REQ-016 SHALL move IDLE -> FETCH when start=1 at a clock edge; internal addr<=0, vec_cnt<=0.
REQ-017 SHALL drive rd_addr from the registered addr at all times; addr is held stable through FETCH, LOAD and SEND.
REQ-018 SHALL move FETCH -> LOAD unconditionally after one cycle, during which the ROM samples rd_addr.
REQ-019 SHALL, in LOAD, capture rom_dout into a_tdata, set a_tvalid<=1, and move to SEND.
REQ-020 SHALL make a_tvalid rise exactly 2 edges after the edge that samples start; a_tdata then equals ROM[0].
REQ-021 SHALL, in SEND, hold a_tvalid and a_tdata stable until a_tvalid&&a_tready at an edge; a_tready low for any number of cycles only stalls.
REQ-022 SHALL, on the SEND handshake edge, clear a_tvalid and increment vec_cnt; if addr==NUM_VEC-1, go to DONE, else addr<=addr+1 and go to FETCH.
REQ-023 SHALL give a throughput of at most one vector per 3 cycles; back-to-back handshakes are not required.
REQ-024 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE.
REQ-025 SHALL ignore start outside IDLE, including start in the DONE cycle.
REQ-026 SHALL let abort=1 at any edge outside IDLE force IDLE and a_tvalid<=0 with no done pulse, with vec_cnt holding its value; abort has priority over a same-edge handshake, and that handshake is not counted.
REQ-027 SHALL restart a new run at addr 0 on start in IDLE after a completed or aborted run.
REQ-028 SHALL never let addr exceed NUM_VEC-1; with NUM_VEC=32 addr reaches 31 with no wrap.
REQ-029 SHALL not change a_tdata outside LOAD.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force: state IDLE, addr 0, rd_addr 0, a_tdata 0, a_tvalid 0, busy 0, done 0, vec_cnt 0.
REQ-031 SHALL, on reset assertion mid-run, drop a_tvalid immediately without waiting for a clock; after release, the block waits in IDLE for start.

Verification
REQ-032 SHALL cover full run: NUM_VEC=20, a_tready=1, start pulse -> 20 handshakes with a_tdata sequence 00f3e301, 06d7cd0d, 3b23f176, ... ending 7f800000; handshakes spaced 3 cycles apart; done pulses once; vec_cnt=20.
REQ-033 SHALL cover backpressure: a_tready=0 for 7 cycles on vector 3 -> a_tvalid=1 and a_tdata=1e8dcd3d held stable through the stall; the sequence is otherwise unchanged.
REQ-034 SHALL cover abort: abort during SEND of vector 5 with a_tready=1 on the same edge -> IDLE next cycle, a_tvalid=0, vec_cnt=5, no done; a new start then begins with 00f3e301.
REQ-035 SHALL cover reset mid-run: rst_n low during LOAD -> all outputs 0 without a clock edge; a later start gives a clean run from address 0.
REQ-036 SHALL cover start ignored: start pulses during busy and in the DONE cycle -> no extra vectors, exactly one done per run.
REQ-037 SHALL cover the bound: NUM_VEC=1 -> one handshake carrying ROM[0], done 1 cycle after it, rd_addr never leaves 0.

Source files
------------

// File: rtl/floating_point_vec_driver.sv
// Floating-point vector driver: walks a 1-cycle-latency ROM from address 0
// to NUM_VEC-1 and presents each word on an AXI-Stream style operand port.
// Handshake: a_tvalid/a_tdata are held stable from the LOAD edge until an
// edge where a_tvalid && a_tready; that edge is the transfer. a_tready may
// stay low for any number of cycles and only stalls the run.
module floating_point_vec_driver #(
    parameter int NUM_VEC = 20,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rom_dout,
    output logic [31:0]       a_tdata,
    output logic              a_tvalid,
    input  logic              a_tready,
    output logic              busy,
    output logic              done,
    output logic [5:0]        vec_cnt,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        SEND  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_VEC - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_nxt;
    logic [31:0]       tdata_nxt;
    logic              tvalid_nxt;
    logic [5:0]        cnt_nxt;

    // State and datapath registers; reset clears everything asynchronously,
    // so a_tvalid drops the moment rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr     <= '0;
            a_tdata  <= '0;
            a_tvalid <= 1'b0;
            vec_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            addr     <= addr_nxt;
            a_tdata  <= tdata_nxt;
            a_tvalid <= tvalid_nxt;
            vec_cnt  <= cnt_nxt;
        end
    end

    // Next-state logic: FETCH gives the ROM its read cycle, LOAD captures the
    // word, SEND waits for the handshake; abort overrides everything.
    always_comb begin
        state_nxt  = state;
        addr_nxt   = addr;
        tdata_nxt  = a_tdata;
        tvalid_nxt = a_tvalid;
        cnt_nxt    = vec_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FETCH;
                    addr_nxt  = '0;
                    cnt_nxt   = '0;
                end
            end
            FETCH: begin
                state_nxt = LOAD;
            end
            LOAD: begin
                tdata_nxt  = rom_dout;
                tvalid_nxt = 1'b1;
                state_nxt  = SEND;
            end
            SEND: begin
                if (a_tvalid && a_tready) begin
                    tvalid_nxt = 1'b0;
                    cnt_nxt    = vec_cnt + 6'd1;
                    if (addr == LAST_ADDR) begin
                        state_nxt = DONE;
                    end else begin
                        addr_nxt  = addr + ADDR_W'(1);
                        state_nxt = FETCH;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // A cancelled run keeps its count and never captures or counts a
        // transfer that coincides with the abort edge.
        if (abort && (state != IDLE)) begin
            state_nxt  = IDLE;
            addr_nxt   = addr;
            tdata_nxt  = a_tdata;
            tvalid_nxt = 1'b0;
            cnt_nxt    = vec_cnt;
        end
    end

    assign rd_addr   = addr;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_floating_point_vec_driver.sv
// Bench for floating_point_vec_driver: one 20-vector instance with a ROM
// model, plus a single-vector instance for the lower bound.
module tb_floating_point_vec_driver;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [4:0]  rd_addr;
    logic [31:0] rom_dout;
    logic [31:0] a_tdata;
    logic        a_tvalid;
    logic        a_tready;
    logic        busy;
    logic        done;
    logic [5:0]  vec_cnt;
    logic [2:0]  state_dbg;

    logic        start1;
    logic        abort1;
    logic [4:0]  rd_addr1;
    logic [31:0] rom1_dout;
    logic [31:0] a_tdata1;
    logic        a_tvalid1;
    logic        a_tready1;
    logic        busy1;
    logic        done1;
    logic [5:0]  vec_cnt1;
    logic [2:0]  state_dbg1;

    logic [31:0] rom [0:31];

    int n_cmp;
    int n_bad;

    // capture results
    logic [31:0] cap_data[$];
    int          cap_cyc[$];
    int          cap_dones;
    int          cap_done_cyc;
    int          cap_first_valid;
    int          cap_stall_bad;
    int          cap_stall_cycles;
    int          cap_end;
    bit          cap_aborted;
    bit          cap_timeout;

    floating_point_vec_driver #(.NUM_VEC(20), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .rd_addr(rd_addr), .rom_dout(rom_dout), .a_tdata(a_tdata),
        .a_tvalid(a_tvalid), .a_tready(a_tready), .busy(busy), .done(done),
        .vec_cnt(vec_cnt), .state_dbg(state_dbg)
    );

    floating_point_vec_driver #(.NUM_VEC(1), .ADDR_W(5)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .rd_addr(rd_addr1), .rom_dout(rom1_dout), .a_tdata(a_tdata1),
        .a_tvalid(a_tvalid1), .a_tready(a_tready1), .busy(busy1), .done(done1),
        .vec_cnt(vec_cnt1), .state_dbg(state_dbg1)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // registered ROM models, one read cycle of latency
    always @(posedge clk) rom_dout  <= rom[rd_addr];
    always @(posedge clk) rom1_dout <= rom[rd_addr1];

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one run on dut starting at posedge+1 and record every transfer.
    // k counts observations made #1 after each edge; k=0 follows the start edge.
    task automatic capture(input int stall_vec, input int stall_len,
                           input int abort_vec, input bit noise, input int max_cyc);
        int          stalled;
        logic [31:0] held;
        cap_data.delete();
        cap_cyc.delete();
        cap_dones = 0;
        cap_done_cyc = -1;
        cap_first_valid = -1;
        cap_stall_bad = 0;
        cap_stall_cycles = 0;
        cap_end = -1;
        cap_aborted = 0;
        cap_timeout = 0;
        stalled = 0;
        held = '0;
        start = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < max_cyc; k++) begin
            a_tready = 1'b1;
            abort = 1'b0;
            start = 1'b0;
            if (a_tvalid && cap_first_valid < 0) cap_first_valid = k;
            if (done) begin
                cap_dones++;
                cap_done_cyc = k;
                if (noise) start = 1'b1;
            end
            if (noise && busy && !done && (k % 4 == 1)) start = 1'b1;
            if (a_tvalid && cap_data.size() == stall_vec && stalled < stall_len) begin
                if (stalled == 0) held = a_tdata;
                else if (a_tdata !== held) cap_stall_bad++;
                a_tready = 1'b0;
                stalled++;
                cap_stall_cycles++;
            end
            if (a_tvalid && a_tready) begin
                if (cap_data.size() == abort_vec) begin
                    abort = 1'b1;
                    cap_aborted = 1'b1;
                end else begin
                    cap_data.push_back(a_tdata);
                    cap_cyc.push_back(k);
                end
            end
            if (!busy) begin
                cap_end = k;
                break;
            end
            @(posedge clk); #1;
        end
        if (cap_end < 0) cap_timeout = 1'b1;
        a_tready = 1'b1;
        abort = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (a_tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid: got %b expected 0", a_tvalid); end
        n_cmp++; if (a_tdata !== 32'h0) begin n_bad++; $display("FAIL reset_tdata: got %h expected 0", a_tdata); end
        n_cmp++; if (rd_addr !== 5'd0) begin n_bad++; $display("FAIL reset_rd_addr: got %0d expected 0", rd_addr); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (vec_cnt !== 6'd0) begin n_bad++; $display("FAIL reset_vec_cnt: got %0d expected 0", vec_cnt); end
        n_cmp++; if (a_tvalid1 !== 1'b0 || busy1 !== 1'b0) begin n_bad++; $display("FAIL reset_dut1: got tvalid %b busy %b expected 0 0", a_tvalid1, busy1); end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_after_release: got busy %b expected 0", busy); end
    endtask

    task automatic test_full_run();
        int exp_done;
        capture(-1, 0, -1, 1'b0, 200);
        n_cmp++; if (cap_timeout !== 1'b0) begin n_bad++; $display("FAIL full_timeout: run did not return to idle within 200 cycles"); end
        n_cmp++; if (cap_data.size() != 20) begin n_bad++; $display("FAIL full_count: got %0d transfers expected 20", cap_data.size()); end
        n_cmp++; if (cap_first_valid != 2) begin n_bad++; $display("FAIL full_first_valid: got cycle %0d expected 2", cap_first_valid); end
        for (int i = 0; i < cap_data.size() && i < 20; i++) begin
            n_cmp++; if (cap_data[i] !== rom[i]) begin n_bad++; $display("FAIL full_data[%0d]: got %h expected %h", i, cap_data[i], rom[i]); end
        end
        for (int i = 1; i < cap_cyc.size(); i++) begin
            n_cmp++; if (cap_cyc[i] - cap_cyc[i-1] != 3) begin n_bad++; $display("FAIL full_spacing[%0d]: got %0d expected 3", i, cap_cyc[i] - cap_cyc[i-1]); end
        end
        n_cmp++; if (cap_dones != 1) begin n_bad++; $display("FAIL full_done_count: got %0d expected 1", cap_dones); end
        exp_done = (cap_cyc.size() > 0) ? cap_cyc[cap_cyc.size()-1] + 1 : -2;
        n_cmp++; if (cap_done_cyc != exp_done) begin n_bad++; $display("FAIL full_done_cycle: got %0d expected %0d", cap_done_cyc, exp_done); end
        n_cmp++; if (cap_end != 61) begin n_bad++; $display("FAIL full_end_cycle: got %0d expected 61", cap_end); end
        n_cmp++; if (vec_cnt !== 6'd20) begin n_bad++; $display("FAIL full_vec_cnt: got %0d expected 20", vec_cnt); end
    endtask

    task automatic test_backpressure();
        int exp_gap;
        capture(3, 7, -1, 1'b0, 200);
        n_cmp++; if (cap_data.size() != 20) begin n_bad++; $display("FAIL bp_count: got %0d expected 20", cap_data.size()); end
        n_cmp++; if (cap_stall_cycles != 7) begin n_bad++; $display("FAIL bp_stall_cycles: got %0d expected 7", cap_stall_cycles); end
        n_cmp++; if (cap_stall_bad != 0) begin n_bad++; $display("FAIL bp_tdata_stable: got %0d changes expected 0", cap_stall_bad); end
        for (int i = 0; i < cap_data.size() && i < 20; i++) begin
            n_cmp++; if (cap_data[i] !== rom[i]) begin n_bad++; $display("FAIL bp_data[%0d]: got %h expected %h", i, cap_data[i], rom[i]); end
        end
        for (int i = 1; i < cap_cyc.size(); i++) begin
            exp_gap = (i == 3) ? 10 : 3;
            n_cmp++; if (cap_cyc[i] - cap_cyc[i-1] != exp_gap) begin n_bad++; $display("FAIL bp_spacing[%0d]: got %0d expected %0d", i, cap_cyc[i] - cap_cyc[i-1], exp_gap); end
        end
        n_cmp++; if (cap_dones != 1) begin n_bad++; $display("FAIL bp_done_count: got %0d expected 1", cap_dones); end
    endtask

    task automatic test_abort();
        capture(-1, 0, 5, 1'b0, 200);
        n_cmp++; if (cap_aborted !== 1'b1) begin n_bad++; $display("FAIL abort_reached: vector 5 never offered"); end
        n_cmp++; if (cap_data.size() != 5) begin n_bad++; $display("FAIL abort_count: got %0d expected 5", cap_data.size()); end
        n_cmp++; if (cap_end != 18) begin n_bad++; $display("FAIL abort_idle_cycle: got %0d expected 18", cap_end); end
        n_cmp++; if (cap_dones != 0) begin n_bad++; $display("FAIL abort_no_done: got %0d expected 0", cap_dones); end
        n_cmp++; if (a_tvalid !== 1'b0) begin n_bad++; $display("FAIL abort_tvalid: got %b expected 0", a_tvalid); end
        n_cmp++; if (vec_cnt !== 6'd5) begin n_bad++; $display("FAIL abort_vec_cnt: got %0d expected 5", vec_cnt); end
        repeat (3) @(posedge clk); #1;
        n_cmp++; if (vec_cnt !== 6'd5 || busy !== 1'b0) begin n_bad++; $display("FAIL abort_hold: got vec_cnt %0d busy %b expected 5 0", vec_cnt, busy); end
        capture(-1, 0, -1, 1'b0, 200);
        n_cmp++; if (cap_data.size() != 20) begin n_bad++; $display("FAIL abort_rerun_count: got %0d expected 20", cap_data.size()); end
        n_cmp++; if (cap_data.size() < 1 || cap_data[0] !== 32'h00f3e301) begin n_bad++; $display("FAIL abort_rerun_first: got %h expected 00f3e301", (cap_data.size() > 0) ? cap_data[0] : 32'hx); end
        n_cmp++; if (cap_dones != 1) begin n_bad++; $display("FAIL abort_rerun_done: got %0d expected 1", cap_dones); end
    endtask

    task automatic test_reset_mid_run();
        // reset while vector 0 is being offered
        start = 1'b1;
        a_tready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk); #1;
        n_cmp++; if (a_tvalid !== 1'b1) begin n_bad++; $display("FAIL rst_send_pre: got tvalid %b expected 1", a_tvalid); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (a_tvalid !== 1'b0) begin n_bad++; $display("FAIL rst_send_tvalid: got %b expected 0", a_tvalid); end
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_wait_idle: got busy %b expected 0", busy); end
        // reset in LOAD of vector 2
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk); #1;
        n_cmp++; if (state_dbg !== 3'd2 || rd_addr !== 5'd2 || vec_cnt !== 6'd2) begin n_bad++; $display("FAIL rst_load_pre: got state %0d addr %0d cnt %0d expected 2 2 2", state_dbg, rd_addr, vec_cnt); end
        n_cmp++; if (a_tdata !== rom[1]) begin n_bad++; $display("FAIL rst_load_pre_tdata: got %h expected %h", a_tdata, rom[1]); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (rd_addr !== 5'd0) begin n_bad++; $display("FAIL rst_load_rd_addr: got %0d expected 0", rd_addr); end
        n_cmp++; if (a_tdata !== 32'h0) begin n_bad++; $display("FAIL rst_load_tdata: got %h expected 0", a_tdata); end
        n_cmp++; if (vec_cnt !== 6'd0) begin n_bad++; $display("FAIL rst_load_vec_cnt: got %0d expected 0", vec_cnt); end
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || a_tvalid !== 1'b0 || state_dbg !== 3'd0) begin n_bad++; $display("FAIL rst_load_ctrl: got busy %b done %b tvalid %b state %0d expected 0 0 0 0", busy, done, a_tvalid, state_dbg); end
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        capture(-1, 0, -1, 1'b0, 200);
        n_cmp++; if (cap_data.size() != 20) begin n_bad++; $display("FAIL rst_rerun_count: got %0d expected 20", cap_data.size()); end
        n_cmp++; if (cap_data.size() < 20 || cap_data[0] !== rom[0] || cap_data[19] !== rom[19]) begin n_bad++; $display("FAIL rst_rerun_data: first/last not ROM[0]/ROM[19], got %0d transfers", cap_data.size()); end
    endtask

    task automatic test_start_ignored();
        capture(-1, 0, -1, 1'b1, 200);
        n_cmp++; if (cap_data.size() != 20) begin n_bad++; $display("FAIL ign_count: got %0d expected 20", cap_data.size()); end
        n_cmp++; if (cap_dones != 1) begin n_bad++; $display("FAIL ign_done_count: got %0d expected 1", cap_dones); end
        n_cmp++; if (cap_end != 61) begin n_bad++; $display("FAIL ign_end_cycle: got %0d expected 61", cap_end); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (busy !== 1'b0 || a_tvalid !== 1'b0) begin n_bad++; $display("FAIL ign_stay_idle[%0d]: got busy %b tvalid %b expected 0 0", i, busy, a_tvalid); end
            @(posedge clk); #1;
        end
        n_cmp++; if (vec_cnt !== 6'd20) begin n_bad++; $display("FAIL ign_vec_cnt: got %0d expected 20", vec_cnt); end
    endtask

    task automatic test_single_vec();
        int          hs;
        int          hs_k;
        int          dcnt;
        int          dk;
        int          addr_bad;
        logic [31:0] hs_data;
        hs = 0; hs_k = -1; dcnt = 0; dk = -1; addr_bad = 0; hs_data = '0;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (rd_addr1 !== 5'd0) addr_bad++;
            if (a_tvalid1 && a_tready1) begin hs++; hs_k = k; hs_data = a_tdata1; end
            if (done1) begin dcnt++; dk = k; end
            @(posedge clk); #1;
        end
        n_cmp++; if (hs != 1) begin n_bad++; $display("FAIL one_hs_count: got %0d expected 1", hs); end
        n_cmp++; if (hs_k != 2) begin n_bad++; $display("FAIL one_hs_cycle: got %0d expected 2", hs_k); end
        n_cmp++; if (hs_data !== rom[0]) begin n_bad++; $display("FAIL one_data: got %h expected %h", hs_data, rom[0]); end
        n_cmp++; if (dcnt != 1) begin n_bad++; $display("FAIL one_done_count: got %0d expected 1", dcnt); end
        n_cmp++; if (dk != 3) begin n_bad++; $display("FAIL one_done_cycle: got %0d expected 3", dk); end
        n_cmp++; if (addr_bad != 0) begin n_bad++; $display("FAIL one_rd_addr: left 0 on %0d cycles expected 0", addr_bad); end
        n_cmp++; if (vec_cnt1 !== 6'd1 || busy1 !== 1'b0) begin n_bad++; $display("FAIL one_end: got cnt %0d busy %b expected 1 0", vec_cnt1, busy1); end
    endtask

    initial begin
        rom[0]  = 32'h00f3e301; rom[1]  = 32'h06d7cd0d; rom[2]  = 32'h3b23f176; rom[3]  = 32'h1e8dcd3d;
        rom[4]  = 32'h3f800000; rom[5]  = 32'h40000000; rom[6]  = 32'hbf800000; rom[7]  = 32'h40490fdb;
        rom[8]  = 32'h00000000; rom[9]  = 32'h80000000; rom[10] = 32'h7f7fffff; rom[11] = 32'h00800000;
        rom[12] = 32'h007fffff; rom[13] = 32'hff800000; rom[14] = 32'h7fc00000; rom[15] = 32'h3eaaaaab;
        rom[16] = 32'hc2c80000; rom[17] = 32'h447a0000; rom[18] = 32'h3dcccccd; rom[19] = 32'h7f800000;
        for (int i = 20; i < 32; i++) rom[i] = 32'hdead0000 + 32'(i);
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; a_tready = 1'b1;
        start1 = 1'b0; abort1 = 1'b0; a_tready1 = 1'b1;
        test_reset();
        test_full_run();
        test_backpressure();
        test_abort();
        test_reset_mid_run();
        test_start_ignored();
        test_single_vec();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
